// File: rtl/branch_predictor_pkg.sv
// Shared encodings for the IF-stage branch predictor.
// Prediction polarity and 2-bit saturating counter states.
package branch_predictor_pkg;

    localparam logic BP_YES = 1'b1;
    localparam logic BP_NO  = 1'b0;

    typedef enum logic [1:0] {
        BP_CTR_SNT = 2'b00,
        BP_CTR_WNT = 2'b01,
        BP_CTR_WT  = 2'b10,
        BP_CTR_ST  = 2'b11
    } bp_ctr_e;

endpackage

// File: rtl/branch_predictor_sat_counter.sv
// 2-bit saturating direction counter, next-state only.
// Used on the BTB training path.
module bp_sat_counter
    import branch_predictor_pkg::*;
(
    input  logic [1:0] ctr,
    input  logic       taken,
    output logic [1:0] ctr_next
);

    always_comb begin
        ctr_next = ctr;
        if (taken) begin
            if (ctr != BP_CTR_ST) begin
                ctr_next = ctr + 2'd1;
            end
        end else begin
            if (ctr != BP_CTR_SNT) begin
                ctr_next = ctr - 2'd1;
            end
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with per-entry 2-bit counters.
// Combinational lookup on if_pc, registered training from EX.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int unsigned INDEX_BITS = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] if_pc,
    output logic        branch_predict,
    output logic [31:0] branch_predict_addr,
    input  logic        ex_update_en,
    input  logic [31:0] ex_pc,
    input  logic        ex_taken,
    input  logic [31:0] ex_target
);

    localparam int unsigned TAG_BITS = 30 - INDEX_BITS;
    localparam int unsigned ENTRIES  = 1 << INDEX_BITS;

    logic                valid_q  [ENTRIES];
    logic [1:0]          ctr_q    [ENTRIES];
    logic [TAG_BITS-1:0] tag_q    [ENTRIES];
    logic [31:0]         target_q [ENTRIES];

    logic [INDEX_BITS-1:0] rd_idx;
    logic [TAG_BITS-1:0]   rd_tag;
    logic                  rd_hit;

    logic [INDEX_BITS-1:0] wr_idx;
    logic [TAG_BITS-1:0]   wr_tag;
    logic                  wr_hit;
    logic [1:0]            wr_ctr;
    logic [1:0]            ctr_inc;
    logic [1:0]            ctr_d;
    logic                  ctr_we;
    logic                  tgt_we;
    logic                  alloc;

    logic unused_pc_bits;
    assign unused_pc_bits = ^{if_pc[1:0], ex_pc[1:0]};

    // Lookup: unwritten entries are masked by valid, so no X escapes.
    assign rd_idx = if_pc[INDEX_BITS+1:2];
    assign rd_tag = if_pc[31:INDEX_BITS+2];
    assign rd_hit = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);

    assign branch_predict =
        (rd_hit && ctr_q[rd_idx][1]) ? BP_YES : BP_NO;
    assign branch_predict_addr =
        (branch_predict == BP_YES) ? target_q[rd_idx] : 32'h0;

    assign wr_idx = ex_pc[INDEX_BITS+1:2];
    assign wr_tag = ex_pc[31:INDEX_BITS+2];
    assign wr_hit = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);
    assign wr_ctr = ctr_q[wr_idx];

    bp_sat_counter u_sat_counter (
        .ctr      (wr_ctr),
        .taken    (ex_taken),
        .ctr_next (ctr_inc)
    );

    always_comb begin
        ctr_d  = ctr_inc;
        ctr_we = 1'b0;
        tgt_we = 1'b0;
        alloc  = 1'b0;
        if (ex_update_en) begin
            if (wr_hit) begin
                ctr_we = 1'b1;
                tgt_we = ex_taken;
            end else if (ex_taken) begin
                alloc  = 1'b1;
                ctr_we = 1'b1;
                tgt_we = 1'b1;
                ctr_d  = BP_CTR_WT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= BP_CTR_WNT;
            end
        end else begin
            if (alloc) begin
                valid_q[wr_idx] <= 1'b1;
            end
            if (ctr_we) begin
                ctr_q[wr_idx] <= ctr_d;
            end
        end
    end

    // Tag/target carry no reset so they can map onto RAM.
    always_ff @(posedge clk) begin
        if (!rst && alloc) begin
            tag_q[wr_idx] <= wr_tag;
        end
        if (!rst && tgt_we) begin
            target_q[wr_idx] <= ex_target;
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor.
// Inputs change on negedge; outputs checked 1 time unit later.
module tb_branch_predictor;

    logic        clk;
    logic        rst;
    logic [31:0] if_pc;
    logic        branch_predict;
    logic [31:0] branch_predict_addr;
    logic        ex_update_en;
    logic [31:0] ex_pc;
    logic        ex_taken;
    logic [31:0] ex_target;

    int checks;
    int errors;

    branch_predictor dut (
        .clk                 (clk),
        .rst                 (rst),
        .if_pc               (if_pc),
        .branch_predict      (branch_predict),
        .branch_predict_addr (branch_predict_addr),
        .ex_update_en        (ex_update_en),
        .ex_pc               (ex_pc),
        .ex_taken            (ex_taken),
        .ex_target           (ex_target)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic upd(input logic [31:0] pc, input logic tk,
                       input logic [31:0] tgt);
        @(negedge clk);
        ex_update_en = 1'b1;
        ex_pc        = pc;
        ex_taken     = tk;
        ex_target    = tgt;
        @(negedge clk);
        ex_update_en = 1'b0;
    endtask

    task automatic look(input string name, input logic [31:0] pc,
                        input logic ep, input logic [31:0] ea);
        if_pc = pc;
        #1;
        checks++;
        if (branch_predict !== ep || branch_predict_addr !== ea) begin
            errors++;
            $display("FAIL %s pc=%h got %b/%h exp %b/%h", name, pc,
                     branch_predict, branch_predict_addr, ep, ea);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        ex_update_en = 1'b0;
        ex_pc = 32'h0;
        ex_taken = 1'b0;
        ex_target = 32'h0;
        if_pc = 32'h0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 64; i++) begin
            look("reset_sweep", 32'(i * 4), 1'b0, 32'h0);
        end
    endtask

    task automatic test_alloc;
        upd(32'h0040_0010, 1'b1, 32'h0040_0100);
        look("alloc", 32'h0040_0010, 1'b1, 32'h0040_0100);
    endtask

    task automatic test_counter;
        upd(32'h0040_0010, 1'b0, 32'hDEAD_0000);
        look("wt_to_wnt", 32'h0040_0010, 1'b0, 32'h0);
        upd(32'h0040_0010, 1'b0, 32'hDEAD_0000);
        look("wnt_to_snt", 32'h0040_0010, 1'b0, 32'h0);
        upd(32'h0040_0010, 1'b0, 32'hDEAD_0000);
        look("snt_sat", 32'h0040_0010, 1'b0, 32'h0);
        upd(32'h0040_0010, 1'b1, 32'h0040_0100);
        look("snt_to_wnt", 32'h0040_0010, 1'b0, 32'h0);
        upd(32'h0040_0010, 1'b1, 32'h0040_0180);
        look("wnt_to_wt", 32'h0040_0010, 1'b1, 32'h0040_0180);
    endtask

    task automatic test_alias;
        look("alias_miss", 32'h0040_1010, 1'b0, 32'h0);
        upd(32'h0040_1010, 1'b1, 32'h0040_2000);
        look("alias_new", 32'h0040_1010, 1'b1, 32'h0040_2000);
        look("alias_old", 32'h0040_0010, 1'b0, 32'h0);
        upd(32'h0040_0010, 1'b0, 32'h0);
        look("miss_nt_nochg", 32'h0040_1010, 1'b1, 32'h0040_2000);
    endtask

    task automatic test_saturate;
        upd(32'h0040_1010, 1'b1, 32'h0040_2000);
        upd(32'h0040_1010, 1'b1, 32'h0040_2000);
        upd(32'h0040_1010, 1'b0, 32'h0);
        look("st_sat", 32'h0040_1010, 1'b1, 32'h0040_2000);
        upd(32'h0040_1010, 1'b0, 32'h0);
        look("wt_to_wnt2", 32'h0040_1010, 1'b0, 32'h0);
    endtask

    task automatic test_align_noen;
        upd(32'h0040_0043, 1'b1, 32'h0040_0444);
        look("align", 32'h0040_0042, 1'b1, 32'h0040_0444);
        @(negedge clk);
        ex_update_en = 1'b0;
        ex_pc = 32'h0040_0050;
        ex_taken = 1'b1;
        ex_target = 32'h0040_0555;
        @(negedge clk);
        look("no_enable", 32'h0040_0050, 1'b0, 32'h0);
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        ex_update_en = 1'b1;
        ex_pc = 32'h0040_0020;
        ex_taken = 1'b1;
        ex_target = 32'h0040_0200;
        look("same_cycle", 32'h0040_0020, 1'b0, 32'h0);
        @(negedge clk);
        ex_update_en = 1'b0;
        look("next_cycle", 32'h0040_0020, 1'b1, 32'h0040_0200);
    endtask

    task automatic test_reset_update;
        @(negedge clk);
        rst = 1'b1;
        ex_update_en = 1'b1;
        ex_pc = 32'h0040_0030;
        ex_taken = 1'b1;
        ex_target = 32'h0040_0300;
        @(negedge clk);
        rst = 1'b0;
        ex_update_en = 1'b0;
        look("rst_over_upd", 32'h0040_0030, 1'b0, 32'h0);
        look("rst_history", 32'h0040_0020, 1'b0, 32'h0);
        look("rst_history2", 32'h0040_1010, 1'b0, 32'h0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset;
        test_alloc;
        test_counter;
        test_alias;
        test_saturate;
        test_align_noen;
        test_back_to_back;
        test_reset_update;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
